// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: one single-bit logical shift per clock, up to N steps.
// Latency: done is high in the cycle after edge E+k+1, where E is the accept edge and k=min(amount,N).
// Backpressure: none; start is sampled only in IDLE or DONE and is ignored while busy.

// Single-bit logical right shift; the bit shifted out is i_data[0].
module shiftRight #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data
);
  assign o_data = {1'b0, i_data[N-1:1]};
endmodule

// Single-bit logical left shift; the bit shifted out is i_data[N-1].
module shiftLeft #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_data,
  output logic [N-1:0] o_data
);
  assign o_data = {i_data[N-2:0], 1'b0};
endmodule

module shift_sequencer #(
  parameter  int N  = 4,
  localparam int AW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          dir,
  input  logic [N-1:0]  data_in,
  input  logic [AW-1:0] amount,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  data_out,
  output logic          carry,
  output logic          zero
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next_state;
  logic [N-1:0]  r_data;
  logic          r_dir;
  logic          r_carry;
  logic [AW-1:0] r_cnt;

  logic [N-1:0]  w_right;
  logic [N-1:0]  w_left;
  logic          w_accept;
  logic          w_cnt_zero;
  logic [AW-1:0] w_k;

  // One shared pair of single-bit shifters serves every shift count.
  shiftRight #(.N(N)) u_shift_right (
    .i_data (r_data),
    .o_data (w_right)
  );

  shiftLeft #(.N(N)) u_shift_left (
    .i_data (r_data),
    .o_data (w_left)
  );

  // A request is only taken when no operation is in flight; DONE accepts for back-to-back ops.
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_cnt_zero = (r_cnt == '0);
  // Counts beyond N would only shift in more zeros, so they saturate at N.
  assign w_k        = (amount > AW'(N)) ? AW'(N) : amount;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: SHIFT runs until the step counter is exhausted.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_cnt_zero) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_SHIFT: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operand on accept, then one shift per cycle while steps remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_dir   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_data  <= data_in;
      r_dir   <= dir;
      r_carry <= 1'b0;
      r_cnt   <= w_k;
    end else if ((r_state == S_SHIFT) && !w_cnt_zero) begin
      r_data  <= r_dir ? w_left : w_right;
      r_carry <= r_dir ? r_data[N-1] : r_data[0];
      r_cnt   <= r_cnt - 1'b1;
    end
  end

  assign data_out = r_data;
  assign carry    = r_carry;
  assign zero     = (r_data == '0);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (N=4): directed vectors plus a full sweep.
// Stimulus pushes expected result/carry/zero/done-cycle; a negedge monitor pops on done.
// No backpressure exercised beyond start being ignored while busy.
module tb_shift_sequencer;

  localparam int N  = 4;
  localparam int AW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          dir;
  logic [N-1:0]  data_in;
  logic [AW-1:0] amount;
  logic          busy;
  logic          done;
  logic [N-1:0]  data_out;
  logic          carry;
  logic          zero;

  typedef struct {
    int           id;
    logic [N-1:0] d;
    logic         c;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   next_id;

  shift_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dir      (dir),
    .data_in  (data_in),
    .amount   (amount),
    .busy     (busy),
    .done     (done),
    .data_out (data_out),
    .carry    (carry),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; read only at negedges.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check($sformatf("op%0d_data", e.id), int'(data_out), int'(e.d));
        check($sformatf("op%0d_carry", e.id), int'(carry), int'(e.c));
        check($sformatf("op%0d_zero", e.id), int'(zero), int'(e.d == 4'b0000));
        check($sformatf("op%0d_done_cycle", e.id), cyc, e.cyc);
      end
    end
  end

  function automatic int sat(input int amt);
    return (amt > N) ? N : amt;
  endfunction

  // Closed-form reference for a k-bit logical shift and the last bit out.
  function automatic void model(input logic [N-1:0] d, input logic dr, input int amt,
                                output logic [N-1:0] res, output logic c);
    int k;
    k = sat(amt);
    if (k == 0) begin
      res = d;
      c   = 1'b0;
    end else if (!dr) begin
      res = d >> k;
      c   = d[k-1];
    end else begin
      res = d << k;
      c   = d[N-k];
    end
  endfunction

  // Issue one op from an idle DUT: start high for one cycle, expectation queued.
  task automatic issue(input logic [N-1:0] d, input logic dr, input int amt,
                       input logic [N-1:0] exp_d, input logic exp_c);
    exp_t e;
    @(negedge clk);
    start   = 1'b1;
    dir     = dr;
    data_in = d;
    amount  = AW'(amt);
    e.id  = next_id;
    e.d   = exp_d;
    e.c   = exp_c;
    e.cyc = cyc + sat(amt) + 2;
    next_id++;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done within %0d cycles expected %0d pending results", t, q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   c0;
    logic [N-1:0] md;
    logic         mc;

    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    next_id  = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dir      = 1'b0;
    data_in  = '0;
    amount   = '0;

    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_data_out", int'(data_out), 0);
    check("reset_carry", int'(carry), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: 1011 >> 1
    issue(4'b1011, 1'b0, 1, 4'b0101, 1'b1);
    check("t1_busy", int'(busy), 1);
    wait_drain();
    // 2: 1011 << 2
    issue(4'b1011, 1'b1, 2, 4'b1100, 1'b0);
    wait_drain();
    // 3: amount 0, both directions
    issue(4'b0110, 1'b0, 0, 4'b0110, 1'b0);
    wait_drain();
    issue(4'b0110, 1'b1, 0, 4'b0110, 1'b0);
    wait_drain();
    // 4: saturating amount
    issue(4'b1001, 1'b0, 7, 4'b0000, 1'b1);
    wait_drain();
    issue(4'b1001, 1'b1, 7, 4'b0000, 1'b1);
    wait_drain();
    issue(4'b1110, 1'b0, 5, 4'b0000, 1'b1);
    wait_drain();

    // 5: start during busy ignored, then start held across DONE for back-to-back
    @(negedge clk);
    c0      = cyc;
    start   = 1'b1;
    dir     = 1'b0;
    data_in = 4'b1011;
    amount  = 3'd3;
    e.id = next_id; e.d = 4'b0001; e.c = 1'b0; e.cyc = c0 + 5;
    next_id++;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    dir     = 1'b1;
    data_in = 4'b1111;
    amount  = 3'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start   = 1'b1;
    dir     = 1'b1;
    data_in = 4'b0110;
    amount  = 3'd1;
    e.id = next_id; e.d = 4'b1100; e.c = 1'b0; e.cyc = c0 + 8;
    next_id++;
    q.push_back(e);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // 6: async reset in the middle of a shift
    issue(4'b1011, 1'b0, 3, 4'b0001, 1'b0);
    @(negedge clk);
    check("t6_mid_data", int'(data_out), 4'b0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_done", int'(done), 0);
    check("t6_rst_data_out", int'(data_out), 0);
    check("t6_rst_carry", int'(carry), 0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_post_rst_busy", int'(busy), 0);
    issue(4'b0111, 1'b1, 1, 4'b1110, 1'b0);
    wait_drain();

    // Sweep every operand, amount and direction against the reference.
    for (int d = 0; d < 16; d++) begin
      for (int a = 0; a < 8; a++) begin
        for (int r = 0; r < 2; r++) begin
          model(4'(d), 1'(r), a, md, mc);
          issue(4'(d), 1'(r), a, md, mc);
          wait_drain();
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
